bcd_seq_conv: RTL and testbench
===============================

# bcd_seq_conv

Parametrised, iterative binary-to-BCD converter (shift-and-add-3, one bit per clock) with valid/ready handshakes on input and output. It adds an overflow flag and a significant-digit count for display blanking. It sits between the frequency/impedance measurement datapath and the digit display/UART formatting logic, trading latency for a single correction stage instead of a fully unrolled combinational array.

## Interface
- BIN_W, 32, width of unsigned binary input (≥ 4)
- DIGITS, 10, number of BCD digits produced (output width 4*DIGITS)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  bin is valid
- in_ready  out  1  converter can accept bin this cycle
- bin  in  BIN_W  unsigned binary value
- out_valid  out  1  bcd/ndig/ovf valid, held until consumed
- out_ready  in  1  consumer accepts result
- bcd  out  4*DIGITS  packed BCD, digit 0 in [3:0]
- ndig  out  $clog2(DIGITS+1)  count of significant digits (1 for value 0)
- ovf  out  1  value not representable in DIGITS digits; bcd then holds low DIGITS digits
- busy  out  1  conversion in progress

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- State machine states are IDLE, SHIFT and DONE.
- IDLE
  - in_ready=1.
  - On in_valid: load the shift register with bin, clear the BCD accumulator and ovf, set counter=BIN_W, go to SHIFT.
- SHIFT, each cycle:
  - Every digit >4 gets +3.
  - Then {accumulator, shift reg} shifts left by 1.
  - If bit 3 of the top digit (after correction) is 1, it is shifted out and ovf is set (sticky).
  - Counter decrements. When the counter reaches 1, the transition goes to DONE on that edge.
  - in_ready=0.
- DONE
  - out_valid=1; bcd, ndig and ovf are stable.
  - On out_ready: if in_valid is also high, the new value is accepted that same edge and the state goes to SHIFT. Otherwise the state goes to IDLE.
  - in_ready = out_ready in DONE (combinational pass-through).
- ndig = index of the most significant nonzero digit + 1, or 1 if all zero. It is registered on the edge entering DONE.
- When ovf=1, ndig reflects the truncated bcd.
- in_valid outside an in_ready cycle is ignored; the bin value is not stored.
- Reset values: state IDLE, out_valid 0, busy 0, bcd 0, ndig 0, ovf 0, counter 0. in_ready is 1 immediately after reset release.
- Reset mid-conversion discards the partial result. No out_valid is produced for the aborted value.

## Timing
- Acceptance edge E0 (in_valid & in_ready). Shifts happen on edges E1…E_BIN_W.
- out_valid rises on edge E_BIN_W: BIN_W cycles from acceptance to result.
- Throughput with out_ready held high: one conversion per BIN_W+1 cycles (back-to-back accept in DONE).
- busy = (state==SHIFT), registered.
- Outputs are registered. The only combinational input-to-output path is out_ready→in_ready.

## Structure
- Package bcd_pkg holds:
  - the state enum {IDLE, SHIFT, DONE};
  - a constant function bcd_digits_for(width) returning the minimum DIGITS for a given width (32→10, 16→5);
  - a localparam BCD_NIB=4.
- Sub-module bcd_dabble_step: combinational, DIGITS-wide add-3 correction plus 1-bit shift. Inputs are acc and in_bit; outputs are acc_next and carry_out, where carry_out feeds ovf.
- Top holds the FSM, counter, registers and ndig priority encoder.

## Test plan
- Zero: bin=0 → after 32 cycles bcd=0x0000000000, ndig=1, ovf=0.
- Full scale: bin=32'hFFFFFFFF → bcd=0x4294967295, ndig=10, ovf=0; out_valid exactly 32 cycles after acceptance.
- Typical: bin=12345678 → bcd=0x0012345678, ndig=8. Then hold out_ready=0 for 5 cycles: outputs are stable, in_ready=0, and a new in_valid is ignored.
- Overflow: BIN_W=16, DIGITS=4, bin=65535 → bcd=0x5535, ovf=1, ndig=4. bin=9999 → bcd=0x9999, ovf=0.
- Back-to-back: out_ready=1 and in_valid=1 with values 100 then 7 → second accepted on the DONE edge. Results are 0x…100 (ndig 3) then 0x…7 (ndig 1), spaced 33 cycles apart.
- Reset mid-SHIFT (assert rst_n=0 at cycle 10): all outputs return to reset values asynchronously. After release, in_ready=1 and a fresh conversion of 42 gives bcd=0x42.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
//   state_t        : converter FSM states
//   BCD_NIB        : bits per BCD digit
//   bcd_digits_for : minimum decimal digits needed for an unsigned width
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int BCD_NIB = 4;

    // ceil(width * log10(2)), with log10(2) approximated as 0.30103.
    function automatic int bcd_digits_for(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One shift-and-add-3 iteration over a DIGITS-wide BCD accumulator.
//   acc       : current BCD accumulator, digit 0 in the low nibble
//   in_bit    : next binary bit entering at the LSB
//   acc_next  : corrected and shifted accumulator
//   carry_out : bit shifted out of the top digit (overflow indicator)
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 10
) (
    input  logic [DIGITS-1:0][BCD_NIB-1:0] acc,
    input  logic                           in_bit,
    output logic [DIGITS-1:0][BCD_NIB-1:0] acc_next,
    output logic                           carry_out
);

    logic [DIGITS-1:0][BCD_NIB-1:0] corr;

    always_comb begin
        corr = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[d] > 4'd4) corr[d] = acc[d] + 4'd3;
        end
        {carry_out, acc_next} = {corr, in_bit};
    end

endmodule

// File: rtl/bcd_seq_conv.sv
// Iterative binary-to-BCD converter, one bit per clock, valid/ready on both
// sides. Produces an overflow flag and a significant-digit count.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, bin is the unsigned value
//   out_valid/out_ready : output handshake for bcd/ndig/ovf
//   bcd                 : packed BCD result, digit 0 in [3:0]
//   ndig                : significant digits (1 for zero)
//   ovf                 : value exceeded DIGITS digits; bcd holds the low digits
//   busy                : conversion in progress
module bcd_seq_conv
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_NIB*DIGITS-1:0]     bcd,
    output logic [$clog2(DIGITS+1)-1:0]   ndig,
    output logic                          ovf,
    output logic                          busy
);

    localparam int NW = $clog2(DIGITS+1);
    localparam int CW = $clog2(BIN_W+1);

    state_t                         state;
    logic [BIN_W-1:0]               sreg;
    logic [DIGITS-1:0][BCD_NIB-1:0] acc, acc_next;
    logic [CW-1:0]                  cnt;
    logic                           carry;
    logic [NW-1:0]                  ndig_next;
    logic                           accept;

    bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
        .acc       (acc),
        .in_bit    (sreg[BIN_W-1]),
        .acc_next  (acc_next),
        .carry_out (carry)
    );

    // Only used on the final shift, so it sees the completed (possibly
    // truncated) result.
    always_comb begin
        ndig_next = NW'(1);
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_next[d] != '0) ndig_next = NW'(d + 1);
        end
    end

    // DONE passes out_ready through so a new value can be taken on the same
    // edge the result is consumed.
    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign bcd      = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            acc       <= '0;
            cnt       <= '0;
            ndig      <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            state     <= SHIFT;
            sreg      <= bin;
            acc       <= '0;
            cnt       <= CW'(BIN_W);
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    acc  <= acc_next;
                    sreg <= sreg << 1;
                    cnt  <= cnt - 1'b1;
                    if (carry) ovf <= 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        ndig      <= ndig_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_conv.sv
module tb_bcd_seq_conv;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 32-bit / 10-digit instance
    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b1, ovf32, busy32;
    logic [31:0] bin32 = '0;
    logic [39:0] bcd32;
    logic [3:0]  nd32;

    // 16-bit / 4-digit instance (overflow cases)
    logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b1, ovf16, busy16;
    logic [15:0] bin16 = '0;
    logic [15:0] bcd16;
    logic [2:0]  nd16;

    bcd_seq_conv #(.BIN_W(32), .DIGITS(10)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .bin(bin32),
        .out_valid(ov32), .out_ready(or32), .bcd(bcd32), .ndig(nd32),
        .ovf(ovf32), .busy(busy32));

    bcd_seq_conv #(.BIN_W(16), .DIGITS(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .bin(bin16),
        .out_valid(ov16), .out_ready(or16), .bcd(bcd16), .ndig(nd16),
        .ovf(ovf16), .busy(busy16));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [39:0] bcd;
        logic [3:0]  nd;
        logic        ovf;
        longint      t_acc;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];

    // Decimal reference: low nd digits, overflow if anything remains.
    function automatic exp_t model(input longint unsigned v, input int nd, input longint t);
        exp_t e;
        e.bcd = '0;
        e.nd  = 4'd1;
        for (int i = 0; i < nd; i++) begin
            e.bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        e.ovf = (v != 0);
        for (int i = 0; i < nd; i++)
            if (e.bcd[4*i +: 4] != 4'd0) e.nd = 4'(i + 1);
        e.t_acc = t;
        return e;
    endfunction

    longint cyc = 0;
    always @(posedge clk) cyc++;

    logic   ovp32 = 1'b0, ovp16 = 1'b0;
    longint rise32_last = 0, rise32_prev = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
            ovp32 = 1'b0;
        end else begin
            if (iv32 && ir32) q32.push_back(model(longint'(bin32), 10, cyc + 1));
            if (ov32 && !ovp32) begin
                rise32_prev = rise32_last;
                rise32_last = cyc;
                if (q32.size() == 0) chk("unexpected_out32", 1, 0);
                else chk("latency32", 64'(cyc - q32[0].t_acc), 32);
            end
            if (ov32 && or32 && q32.size() != 0) begin
                exp_t e;
                e = q32.pop_front();
                chk("bcd32", bcd32, e.bcd);
                chk("ndig32", nd32, e.nd);
                chk("ovf32", ovf32, e.ovf);
            end
            ovp32 = ov32;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q16.delete();
            ovp16 = 1'b0;
        end else begin
            if (iv16 && ir16) q16.push_back(model(longint'(bin16), 4, cyc + 1));
            if (ov16 && !ovp16) begin
                if (q16.size() == 0) chk("unexpected_out16", 1, 0);
                else chk("latency16", 64'(cyc - q16[0].t_acc), 16);
            end
            if (ov16 && or16 && q16.size() != 0) begin
                exp_t e;
                e = q16.pop_front();
                chk("bcd16", bcd16, 64'(e.bcd[15:0]));
                chk("ndig16", nd16, 64'(e.nd));
                chk("ovf16", ovf16, e.ovf);
            end
            ovp16 = ov16;
        end
    end

    task automatic send32(input logic [31:0] v);
        bit ok = 0;
        iv32 = 1'b1;
        bin32 = v;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ir32) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout32", 0, 1);
        @(posedge clk); #1;
        iv32 = 1'b0;
    endtask

    task automatic send16(input logic [15:0] v);
        bit ok = 0;
        iv16 = 1'b1;
        bin16 = v;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ir16) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout16", 0, 1);
        @(posedge clk); #1;
        iv16 = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (q32.size() == 0 && q16.size() == 0 && !ov32 && !ov16) begin ok = 1; break; end
        end
        if (!ok) chk(tag, 0, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ov"},   ov32, 0);
        chk({tag, "_busy"}, busy32, 0);
        chk({tag, "_bcd"},  bcd32, 0);
        chk({tag, "_ndig"}, nd32, 0);
        chk({tag, "_ovf"},  ovf32, 0);
        chk({tag, "_ir"},   ir32, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk_reset("rst");
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ir16", ir16, 1);
        @(posedge clk); #1;

        // Zero and full scale
        send32(32'd0);
        drain("drain_zero");
        send32(32'hFFFF_FFFF);
        @(negedge clk);
        chk("busy_in_shift", busy32, 1);
        chk("ir_in_shift", ir32, 0);
        drain("drain_full");

        // Typical value with consumer stalled; new in_valid must be ignored
        or32 = 1'b0;
        send32(32'd12345678);
        begin
            bit ok = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (ov32) begin ok = 1; break; end
            end
            if (!ok) chk("ov_timeout", 0, 1);
        end
        iv32 = 1'b1;
        bin32 = 32'd999;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ov", ov32, 1);
            chk("stall_bcd", bcd32, 40'h0012345678);
            chk("stall_ndig", nd32, 8);
            chk("stall_ir", ir32, 0);
        end
        @(posedge clk); #1;
        iv32 = 1'b0;
        or32 = 1'b1;
        drain("drain_typ");

        // Back-to-back: second value taken on the DONE edge
        iv32 = 1'b1;
        bin32 = 32'd100;
        begin
            bit ok = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (ir32) begin ok = 1; break; end
            end
            if (!ok) chk("b2b_acc1", 0, 1);
            @(posedge clk); #1;
            bin32 = 32'd7;
            ok = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (ir32) begin ok = 1; break; end
            end
            if (!ok) chk("b2b_acc2", 0, 1);
            chk("b2b_ov_at_acc2", ov32, 1);
            @(posedge clk); #1;
            iv32 = 1'b0;
        end
        drain("drain_b2b");
        chk("b2b_spacing", 64'(rise32_last - rise32_prev), 33);

        // Overflow on the narrow instance
        send16(16'd65535);
        drain("drain_ovf");
        send16(16'd9999);
        drain("drain_9999");
        send16(16'd10000);
        drain("drain_10000");

        // Reset mid-conversion
        send32(32'd12345);
        repeat (9) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy32, 1);
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ir", ir32, 1);
        send32(32'd42);
        drain("drain_42");
        chk("final_bcd", bcd32, 40'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
